btn_debounce_multi: RTL and testbench



---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce_ch.sv | 130 +++++++++++++
 rtl/btn_debounce_multi.sv | 60 ++++++
 tb/tb_btn_debounce_multi.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel button conditioner.
//   btn_state_e  : per-channel FSM state encoding
//   hold_cnt_w() : width of the per-channel hold counter, able to hold
//                  max(long_ticks, repeat_ticks)
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_e;

  function automatic int unsigned hold_cnt_w(input int unsigned long_ticks,
                                             input int unsigned repeat_ticks);
    int unsigned m;
    m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-sampled shift register with
// set-on-all-ones / clear-on-all-zeros hysteresis, and a press/hold/repeat FSM.
//   clk, reset : system clock, asynchronous active-high reset
//   i_tick     : one-clk sample strobe shared by all channels
//   i_btn      : raw asynchronous button input (1 = pressed)
//   o_level    : debounced level
//   o_press    : one-clk pulse as o_level rises
//   o_release  : one-clk pulse as o_level falls
//   o_repeat   : one-clk auto-repeat pulse while held
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned HOLD_W = hold_cnt_w(LONG_TICKS, REPEAT_TICKS);
  localparam logic [HOLD_W-1:0] LONG_LAST = (LONG_TICKS == 0) ? '0 : HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  logic [1:0]        r_sync;
  logic [DEPTH-1:0]  r_sh;
  logic              r_level;
  logic              r_press, r_release, r_repeat;
  btn_state_e        r_state, w_state_next;
  logic [HOLD_W-1:0] r_hold, w_hold_next;
  logic              w_level_next, w_press_next, w_release_next, w_repeat_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_sh   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (i_tick) r_sh <= {r_sync[1], r_sh[DEPTH-1:1]};
    end
  end

  always_comb begin
    w_level_next = r_level;
    if (&r_sh)       w_level_next = 1'b1;
    else if (~|r_sh) w_level_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_repeat  <= w_repeat_next;
    end
  end

  // Release is checked before the tick branch so a due repeat is dropped.
  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_repeat_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_level_next) begin
          w_state_next = PRESSED;
          w_press_next = 1'b1;
          w_hold_next  = '0;
        end
      end
      PRESSED: begin
        if (!w_level_next) begin
          w_state_next   = IDLE;
          w_release_next = 1'b1;
          w_hold_next    = '0;
        end else if (i_tick) begin
          if (LONG_TICKS != 0 && r_hold == LONG_LAST) begin
            w_state_next  = REPEAT;
            w_repeat_next = 1'b1;
            w_hold_next   = '0;
          end else if (r_hold != HOLD_MAX) begin
            w_hold_next = r_hold + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!w_level_next) begin
          w_state_next   = IDLE;
          w_release_next = 1'b1;
          w_hold_next    = '0;
        end else if (i_tick) begin
          if (r_hold == REP_LAST) begin
            w_repeat_next = 1'b1;
            w_hold_next   = '0;
          end else begin
            w_hold_next = r_hold + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_hold_next  = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner with one shared sample-tick generator.
//   clk, reset : system clock, asynchronous active-high reset
//   i_btn      : raw asynchronous buttons, 1 = pressed
//   o_level    : debounced level per channel
//   o_press    : one-clk pulse when o_level rises
//   o_release  : one-clk pulse when o_level falls
//   o_repeat   : one-clk pulse per auto-repeat event while held
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned CLK_DIV      = 100_000,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_repeat
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;

  // Tick is registered: high for the single clk following count==CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_LAST);
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEPTH       (DEPTH),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_tick   (r_tick),
      .i_btn    (i_btn[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_repeat (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi. A behavioural model tracks,
// per channel, the run of identical samples and the number of ticks held,
// and is compared against the DUT every clk.
module tb_btn_debounce_multi;

  localparam int unsigned N  = 4;
  localparam int unsigned CD = 4;
  localparam int unsigned DP = 4;
  localparam int unsigned LT = 10;
  localparam int unsigned RT = 3;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] o_level, o_press, o_release, o_repeat;

  int checks = 0;
  int errors = 0;

  btn_debounce_multi #(
    .N_BTN(N), .CLK_DIV(CD), .DEPTH(DP), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned  m_edges;
  logic [N-1:0] m_d1, m_d2, m_run_val;
  logic [N-1:0] m_level, m_press, m_release, m_repeat;
  int unsigned  m_run_len [N];
  int unsigned  m_held    [N];

  task automatic model_reset();
    m_edges = 0; m_d1 = '0; m_d2 = '0; m_run_val = '0;
    m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
    for (int c = 0; c < N; c++) begin m_run_len[c] = DP; m_held[c] = 0; end
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    logic smp, nl, ol;
    if (reset) begin model_reset(); return; end
    m_edges++;
    smp = (m_edges > CD) && (((m_edges - 1) % CD) == 0);
    s = m_d2; m_d2 = m_d1; m_d1 = i_btn;
    for (int c = 0; c < N; c++) begin
      ol = m_level[c];
      nl = (m_run_len[c] >= DP) ? m_run_val[c] : ol;
      m_press[c]   = nl & ~ol;
      m_release[c] = ol & ~nl;
      m_repeat[c]  = 1'b0;
      if (nl && !ol) m_held[c] = 0;
      else if (nl && ol && smp) begin
        m_held[c]++;
        if (LT != 0 && (m_held[c] == LT || (m_held[c] > LT && ((m_held[c] - LT) % RT) == 0)))
          m_repeat[c] = 1'b1;
      end
      m_level[c] = nl;
      if (smp) begin
        if (s[c] == m_run_val[c]) begin
          if (m_run_len[c] < DP) m_run_len[c]++;
        end else begin
          m_run_val[c] = s[c];
          m_run_len[c] = 1;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_btn = '0; model_reset();
    repeat (3) @(negedge clk);
    if ({o_level, o_press, o_release, o_repeat} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0000", {o_level, o_press, o_release, o_repeat});
    end
    checks++;
    reset = 1'b0;
    for (int i = 0; i < 3 * CD; i++) begin
      i_btn = N'($urandom_range(0, 15)) & {N{i < 2}};
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL reset_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
  endtask

  task automatic test_clean_press();
    int unsigned presses = 0, lat = 0, phase;
    phase = $urandom_range(0, 7);
    i_btn = '0;
    for (int i = 0; i < int'(phase) + 2 * int'(CD) + 2; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL clean_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
    i_btn = 4'b0001;
    for (int i = 1; i <= 8 * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL clean_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_press[0]) begin presses++; if (lat == 0) lat = i; end
    end
    if (presses != 1) begin errors++; $display("FAIL clean_press_count got %0d expected 1", presses); end
    checks++;
    if (lat < DP * CD || lat > (DP + 1) * CD + 3) begin
      errors++; $display("FAIL clean_press_latency got %0d expected %0d..%0d", lat, DP * CD, (DP + 1) * CD + 3);
    end
    checks++;
    if (o_level !== 4'b0001) begin errors++; $display("FAIL clean_level got %b expected 0001", o_level); end
    checks++;
    i_btn = '0;
    for (int i = 0; i < (DP + 3) * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL clean_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
  endtask

  task automatic test_bounce();
    int unsigned pulses = 0, presses = 0, releases = 0;
    repeat ($urandom_range(0, 5)) advance();
    for (int i = 0; i < 40; i++) begin
      i_btn[1] = ((i / 3) % 2 == 0);
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL bounce_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_press[1] || o_release[1]) pulses++;
    end
    if (pulses != 0) begin errors++; $display("FAIL bounce_quiet got %0d pulses expected 0", pulses); end
    checks++;
    i_btn[1] = 1'b1;
    for (int i = 0; i < 8 * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL bounce_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_press[1]) presses++;
    end
    if (presses != 1) begin errors++; $display("FAIL bounce_press_count got %0d expected 1", presses); end
    checks++;
    for (int i = 0; i < 8 * CD; i++) begin
      i_btn[1] = (i >= 2 * CD);
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL glitch_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_release[1]) releases++;
    end
    if (releases != 0 || o_level[1] !== 1'b1) begin
      errors++; $display("FAIL glitch_hold got releases=%0d level=%b expected 0 and 1", releases, o_level[1]);
    end
    checks++;
    i_btn = '0;
    for (int i = 0; i < (DP + 3) * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL bounce_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
  endtask

  task automatic test_auto_repeat();
    bit found = 0, rel = 0;
    int unsigned reps = 0, first = 0, late = 0, rels = 0;
    repeat ($urandom_range(0, 3)) advance();
    i_btn = 4'b0100;
    for (int i = 0; i < (DP + 4) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL repeat_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_level[2]) found = 1;
    end
    if (!found) begin errors++; $display("FAIL repeat_rise_timeout got level 0 expected 1"); end
    checks++;
    for (int j = 1; j <= 25 * CD - 2; j++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL repeat_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_repeat[2]) begin reps++; if (first == 0) first = j; end
    end
    if (reps != 5) begin errors++; $display("FAIL repeat_count got %0d expected 5", reps); end
    checks++;
    if (first != LT * CD - 1) begin errors++; $display("FAIL repeat_first got %0d expected %0d", first, LT * CD - 1); end
    checks++;
    i_btn = '0;
    for (int i = 0; i < (DP + 4) * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL repeat_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (rel && o_repeat[2]) late++;
      if (o_release[2]) begin rels++; rel = 1; end
    end
    if (rels != 1 || late != 0) begin
      errors++; $display("FAIL repeat_release got releases=%0d late_repeats=%0d expected 1 and 0", rels, late);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    bit found = 0;
    i_btn = '1;
    for (int i = 0; i < (DP + 4) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL simul_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_press != '0) found = 1;
    end
    if (o_press !== 4'b1111) begin errors++; $display("FAIL simul_press got %b expected 1111", o_press); end
    checks++;
    for (int i = 0; i < 3 * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL simul_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
    i_btn = 4'b1010;
    found = 0;
    for (int i = 0; i < (DP + 4) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL simul_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_release != '0) found = 1;
    end
    if (o_release !== 4'b0101 || o_level !== 4'b1010) begin
      errors++; $display("FAIL simul_release got rel=%b lvl=%b expected 0101 1010", o_release, o_level);
    end
    checks++;
    i_btn = '0;
    for (int i = 0; i < (DP + 3) * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL simul_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_hold();
    bit found = 0;
    int unsigned n = 0, m = 0;
    i_btn = 4'b0001;
    for (int i = 0; i < (DP + LT + 4) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL rstmid_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_repeat[0]) found = 1;
    end
    if (!found) begin errors++; $display("FAIL rstmid_repeat_timeout got no repeat expected one"); end
    checks++;
    advance();
    #2 reset = 1'b1;
    #1;
    if ({o_level, o_press, o_release, o_repeat} !== 16'h0) begin
      errors++; $display("FAIL rstmid_async got %h expected 0000", {o_level, o_press, o_release, o_repeat});
    end
    checks++;
    model_reset();
    repeat (3) advance();
    reset = 1'b0;
    found = 0;
    for (int i = 1; i <= (DP + 3) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL rstmid_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_press[0]) begin found = 1; n = i; end
    end
    if (n != DP * CD + 2) begin errors++; $display("FAIL rstmid_press_lat got %0d expected %0d", n, DP * CD + 2); end
    checks++;
    found = 0;
    for (int i = 1; i <= (LT + 2) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL rstmid_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_repeat[0]) begin found = 1; m = i; end
    end
    if (m != LT * CD - 1) begin errors++; $display("FAIL rstmid_first_repeat got %0d expected %0d", m, LT * CD - 1); end
    checks++;
    i_btn = '0;
    for (int i = 0; i < (DP + 3) * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL rstmid_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
  endtask

  task automatic test_release_vs_repeat();
    bit found = 0;
    int unsigned lat = 0;
    i_btn = 4'b1000;
    for (int i = 0; i < (DP + LT + 4) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL collide_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_repeat[3]) found = 1;
    end
    if (!found) begin errors++; $display("FAIL collide_repeat_timeout got no repeat expected one"); end
    checks++;
    // Drop the button so the shift register empties on the tick where the
    // second repeat after this one falls due.
    for (int i = 0; i < 7; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL collide_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
    i_btn = '0;
    found = 0;
    for (int i = 1; i <= (DP + 4) * CD && !found; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL collide_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if (o_release[3]) begin found = 1; lat = i; end
    end
    if (!found || o_repeat[3] !== 1'b0) begin
      errors++; $display("FAIL collide_release got release=%0d repeat=%b expected 1 and 0", found, o_repeat[3]);
    end
    checks++;
    if (lat != 2 * RT * CD + 1 - 7) begin
      errors++; $display("FAIL collide_release_lat got %0d expected %0d", lat, 2 * RT * CD + 1 - 7);
    end
    checks++;
    for (int i = 0; i < (DP + 3) * CD; i++) begin
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL collide_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int unsigned rate;
    for (int i = 0; i < 2500; i++) begin
      rate = (i < 1000) ? 16 : 150;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, rate - 1) == 0) i_btn[c] = ~i_btn[c];
      advance();
      if ({o_level, o_press, o_release, o_repeat} !== {m_level, m_press, m_release, m_repeat}) begin
        errors++; $display("FAIL random_model t=%0t got %h expected %h", $time, {o_level, o_press, o_release, o_repeat}, {m_level, m_press, m_release, m_repeat});
      end
      checks++;
      if ((o_press & o_release) != '0) begin
        errors++; $display("FAIL random_press_release_overlap got %b expected 0000", o_press & o_release);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_release_vs_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
